// File: rtl/koa_pkg.sv
// -----------------------------------------------------------------------------
// koa_pkg
// Shared definitions for the Karatsuba multiplier scheduler:
//   - koa_state_e        : scheduler state encoding (IDLE, SETTLE, LOAD, RESP)
//   - KOA_NREQ           : number of requesters sharing the multiplier (2)
//   - KOA_SW_DEF         : default significand width used by the FPU top
//   - KOA_SETTLE_CYC_DEF : default operand settle time in cycles
//   - koa_onehot()       : requester index -> one-hot requester vector
// No ports (package).
// -----------------------------------------------------------------------------
package koa_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LOAD   = 2'd2,
      RESP   = 2'd3
   } koa_state_e;

   localparam int KOA_NREQ           = 2;
   localparam int KOA_SW_DEF         = 24;
   localparam int KOA_SETTLE_CYC_DEF = 2;

   // Convert a requester index into its one-hot request/response lane.
   function automatic logic [KOA_NREQ-1:0] koa_onehot(input logic idx);
      koa_onehot = idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/koa_rr_arb2.sv
// -----------------------------------------------------------------------------
// koa_rr_arb2
// Two-way grant logic for the multiplier scheduler. With both requesters
// valid, the one that did not win last time is granted; a lone valid
// requester always wins. The last winner is remembered only on accept.
//
// Build option: KOA_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a tie, no last-winner register.
//   undefined -> round-robin (default).
//
// Ports:
//   clk       in  1  clock
//   rst       in  1  asynchronous active-high reset
//   i_valid   in  2  candidate requests (already qualified by the caller)
//   i_accept  in  1  the current grant is being taken this cycle
//   o_grant   out 2  one-hot grant (combinational)
// -----------------------------------------------------------------------------
module koa_rr_arb2
   import koa_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [KOA_NREQ-1:0] i_valid,
   input  logic                i_accept,
   output logic [KOA_NREQ-1:0] o_grant
);

`ifdef KOA_ARB_FIXED_PRIO_EN

   // Fixed priority needs no state; fold the unused inputs away.
   logic w_unused;
   assign w_unused = clk ^ rst ^ i_accept;

   // Requester 0 wins every tie.
   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = 2'b01;
         default: o_grant = 2'b00;
      endcase
   end

`else

   // Reset to 1 so requester 0 wins the first tie.
   logic r_last_gnt;

   // Remember the winner of each accepted grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_gnt <= 1'b1;
      end else if (i_accept) begin
         r_last_gnt <= o_grant[1];
      end else begin
         r_last_gnt <= r_last_gnt;
      end
   end

   // Round-robin pick: on a tie, the requester that did not win last time.
   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_last_gnt ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

`endif

endmodule

// File: rtl/koa_mult_arbiter.sv
// -----------------------------------------------------------------------------
// koa_mult_arbiter
// Schedules two requesters onto one shared Karatsuba significand multiplier.
// A granted operand pair is latched onto the multiplier inputs, held for
// SETTLE_CYC cycles, the multiplier result register is loaded with a one-cycle
// pulse, and the product is presented to the owning requester until taken.
//
// Build option: KOA_ARB_FIXED_PRIO_EN (see koa_rr_arb2) selects fixed priority
// for requester 0 instead of round-robin.
//
// Parameters:
//   SW          significand width (multiplier is SW x SW -> 2*SW)
//   SETTLE_CYC  operand hold time before the load pulse, 1..15
//
// Ports:
//   clk           in   1     clock
//   rst           in   1     asynchronous active-high reset (shared with mult)
//   req_valid_i   in   2     request valid per requester
//   req_ready_o   out  2     request accepted when valid & ready
//   req_a_i       in   2*SW  operand A, requester n at [n*SW +: SW]
//   req_b_i       in   2*SW  operand B, same packing
//   rsp_valid_o   out  2     product valid for requester n
//   rsp_ready_i   in   2     requester n takes the product
//   rsp_data_o    out  2*SW  product, qualified by rsp_valid_o
//   mul_a_o       out  SW    multiplier operand A
//   mul_b_o       out  SW    multiplier operand B
//   mul_load_o    out  1     multiplier result-register load
//   mul_result_i  in   2*SW  multiplier result register
//   busy_o        out  1     high whenever not IDLE
// -----------------------------------------------------------------------------
module koa_mult_arbiter
   import koa_pkg::*;
#(
   parameter int SW         = KOA_SW_DEF,
   parameter int SETTLE_CYC = KOA_SETTLE_CYC_DEF
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  logic [2*SW-1:0]     req_a_i,
   input  logic [2*SW-1:0]     req_b_i,
   output logic [1:0]          rsp_valid_o,
   input  logic [1:0]          rsp_ready_i,
   output logic [2*SW-1:0]     rsp_data_o,
   output logic [SW-1:0]       mul_a_o,
   output logic [SW-1:0]       mul_b_o,
   output logic                mul_load_o,
   input  logic [2*SW-1:0]     mul_result_i,
   output logic                busy_o
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

   koa_state_e    r_state;
   koa_state_e    w_state_nxt;
   logic [3:0]    r_cnt;
   logic          r_owner;
   logic [SW-1:0] r_mul_a;
   logic [SW-1:0] r_mul_b;
   logic [1:0]    r_rsp_valid;
   logic          r_mul_load;
   logic          r_busy;

   logic [1:0]    w_arb_valid;
   logic [1:0]    w_grant;
   logic          w_accept;
   logic          w_win;

   // Requests are only eligible while idle; otherwise they wait.
   assign w_arb_valid = (r_state == IDLE) ? req_valid_i : 2'b00;
   assign w_win       = w_grant[1];

   koa_rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (w_arb_valid),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   // Next-state and accept decode.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant != 2'b00) begin
               w_accept    = 1'b1;
               w_state_nxt = SETTLE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SETTLE: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = LOAD;
            end else begin
               w_state_nxt = SETTLE;
            end
         end
         LOAD: begin
            w_state_nxt = RESP;
         end
         RESP: begin
            // Only the owner's ready can release the response.
            if (rsp_ready_i[r_owner]) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = RESP;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Settle counter: loaded on accept, counts down while settling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 4'd0;
      end else if (w_accept) begin
         r_cnt <= CNT_INIT;
      end else if ((r_state == SETTLE) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Operand and owner capture; operands stay put until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner <= 1'b0;
         r_mul_a <= {SW{1'b0}};
         r_mul_b <= {SW{1'b0}};
      end else if (w_accept) begin
         r_owner <= w_win;
         r_mul_a <= w_win ? req_a_i[2*SW-1:SW] : req_a_i[SW-1:0];
         r_mul_b <= w_win ? req_b_i[2*SW-1:SW] : req_b_i[SW-1:0];
      end else begin
         r_owner <= r_owner;
         r_mul_a <= r_mul_a;
         r_mul_b <= r_mul_b;
      end
   end

   // Status outputs registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul_load  <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_valid <= 2'b00;
      end else begin
         r_mul_load  <= (w_state_nxt == LOAD);
         r_busy      <= (w_state_nxt != IDLE);
         r_rsp_valid <= (w_state_nxt == RESP) ? koa_onehot(r_owner) : 2'b00;
      end
   end

   // Ready must answer in the same cycle as valid, so it is the live grant.
   assign req_ready_o = w_arb_valid & w_grant;
   assign rsp_valid_o = r_rsp_valid;
   // The multiplier register holds after LOAD, so the product is stable here.
   assign rsp_data_o  = (r_state == RESP) ? mul_result_i : {(2*SW){1'b0}};
   assign mul_a_o     = r_mul_a;
   assign mul_b_o     = r_mul_b;
   assign mul_load_o  = r_mul_load;
   assign busy_o      = r_busy;

endmodule
